// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation reference datapath.
package me_pkg;

   localparam int unsigned PIXEL          = 8;
   localparam int unsigned WORD_W         = 8 * PIXEL;
   localparam int unsigned BANK_DEPTH_DEF = 96;
   localparam int unsigned BURST_LEN_DEF  = 24;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      FULL
   } ld_state_e;

   // Counter width for values 0..v-1, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/ref_wr_cnt.sv
// Cascaded word/bank/pass write counter for the reference bank loader.
// Advances once per written word; all three levels wrap together after the
// last word of a window, so the next window starts at bank 0 without a clear.
module ref_wr_cnt
   import me_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned BURST_LEN = BURST_LEN_DEF,
   parameter int unsigned PASSES    = BANK_DEPTH_DEF / BURST_LEN_DEF,
   localparam int unsigned BankW    = clog2_min1(NUM_BANKS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [BankW-1:0] bank_idx,
   output logic             last
);

   localparam int unsigned WordW = clog2_min1(BURST_LEN);
   localparam int unsigned PassW = clog2_min1(PASSES);

   logic [WordW-1:0] word_q, word_d;
   logic [BankW-1:0] bank_q, bank_d;
   logic [PassW-1:0] pass_q, pass_d;

   logic word_wrap, bank_wrap, pass_wrap;

   // Wrap detection and cascaded next-count.
   always_comb begin
      word_wrap = (word_q == WordW'(BURST_LEN - 1));
      bank_wrap = (bank_q == BankW'(NUM_BANKS - 1));
      pass_wrap = (pass_q == PassW'(PASSES - 1));
      word_d    = word_q;
      bank_d    = bank_q;
      pass_d    = pass_q;
      if (en) begin
         if (word_wrap) begin
            word_d = '0;
            if (bank_wrap) begin
               bank_d = '0;
               pass_d = pass_wrap ? '0 : pass_q + 1'b1;
            end else begin
               bank_d = bank_q + 1'b1;
            end
         end else begin
            word_d = word_q + 1'b1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
         bank_q <= '0;
         pass_q <= '0;
      end else begin
         word_q <= word_d;
         bank_q <= bank_d;
         pass_q <= pass_d;
      end
   end

   assign bank_idx = bank_q;
   assign last     = word_wrap && bank_wrap && pass_wrap;

endmodule

// File: rtl/ref_bank_loader.sv
// Reference bank loader: steers a 64-bit word stream round-robin, in bursts,
// into NUM_BANKS reference banks until a full search window is written.
// The window-consumed pulse is named win_release since "release" is reserved.
module ref_bank_loader
   import me_pkg::*;
#(
   parameter int unsigned NUM_BANKS  = 4,
   parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
   parameter int unsigned BANK_DEPTH = BANK_DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_W-1:0]    in_data,
   input  logic                 in_sof,
   input  logic                 win_release,
   output logic                 beg_en,
   output logic [WORD_W-1:0]    ref_in,
   output logic [NUM_BANKS-1:0] bank_sel,
   output logic                 fill_done,
   output logic                 err
);

   localparam int unsigned PASSES = BANK_DEPTH / BURST_LEN;
   localparam int unsigned BankW  = clog2_min1(NUM_BANKS);

   ld_state_e state_q, state_d;

   logic                 beg_en_q, beg_en_d;
   logic [WORD_W-1:0]    ref_in_q, ref_in_d;
   logic [NUM_BANKS-1:0] bank_sel_q, bank_sel_d;
   logic                 fill_done_q, fill_done_d;
   logic                 err_q, err_d;

   logic             accept;
   logic             wr_en;
   logic [BankW-1:0] cnt_bank_idx;
   logic             cnt_last;

   ref_wr_cnt #(
      .NUM_BANKS (NUM_BANKS),
      .BURST_LEN (BURST_LEN),
      .PASSES    (PASSES)
   ) u_wr_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (wr_en),
      .bank_idx (cnt_bank_idx),
      .last     (cnt_last)
   );

   // Ready depends on state only so upstream never sees a valid->ready path.
   assign in_ready = (state_q != FULL);
   assign accept   = in_valid && in_ready;
   // Words before the first sof are dropped; mid-fill sof words still write.
   assign wr_en    = accept && ((state_q == FILL) || ((state_q == IDLE) && in_sof));

   // Next state and next values of the registered bank-side outputs.
   always_comb begin
      state_d     = state_q;
      beg_en_d    = wr_en;
      ref_in_d    = ref_in_q;
      fill_done_d = wr_en && cnt_last;
      err_d       = err_q || (accept && (state_q == FILL) && in_sof);
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
         bank_sel_d[i] = !(wr_en && (cnt_bank_idx == BankW'(i)));
      end
      if (wr_en) begin
         ref_in_d = in_data;
      end
      unique case (state_q)
         IDLE: if (wr_en) state_d = cnt_last ? FULL : FILL;
         FILL: if (wr_en && cnt_last) state_d = FULL;
         FULL: if (win_release) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beg_en_q    <= 1'b0;
         ref_in_q    <= '0;
         bank_sel_q  <= '1;
         fill_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         beg_en_q    <= beg_en_d;
         ref_in_q    <= ref_in_d;
         bank_sel_q  <= bank_sel_d;
         fill_done_q <= fill_done_d;
         err_q       <= err_d;
      end
   end

   assign beg_en    = beg_en_q;
   assign ref_in    = ref_in_q;
   assign bank_sel  = bank_sel_q;
   assign fill_done = fill_done_q;
   assign err       = err_q;

endmodule
